// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, widths and address helpers for the icache miss controller
package icache_pkg;

    localparam int IC_IDX_W  = 5;   // 32 cache lines
    localparam int IC_TAG_W  = 8;   // stored tag = addr[15:8]
    localparam int IC_MTAG_W = 4;   // memory transaction tag, 0 = no transaction

    // Bus command encoding seen by the memory side.
    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } bus_cmd_e;

    // Miss FSM: IDLE serves hits and may launch a load, WAIT holds one outstanding miss.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ic_state_e;

    // Line index: bits just above the 8-byte block offset.
    function automatic logic [IC_IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[3 +: IC_IDX_W];
    endfunction

    // Stored tag: bits just above the index.
    function automatic logic [IC_TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[3 + IC_IDX_W +: IC_TAG_W];
    endfunction

    // Block-aligned byte address of the 64-bit block holding addr.
    function automatic logic [31:0] block_align(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped icache miss controller, one outstanding bus load
//
// Ports:
//   clock, reset_n                      clock, asynchronous active-low reset
//   proc2Icache_req/addr                fetch request and byte address
//   Icache_data_out/valid_out           hit data / hit indication for the current fetch
//   cache_rd_idx/tag, cache_rd_data/valid   array lookup (index/tag out, data/hit in)
//   cache_wr_en/idx/tag/data            array fill write
//   mem_command/addr                    bus load request
//   mem_response                        nonzero = load accepted, value is its transaction tag
//   mem_data/mem_tag                    returned block and its transaction tag (0 = nothing)
//   miss_count                          number of accepted misses, wraps
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 8,
    parameter int MTAG_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              proc2Icache_req,
    input  logic [31:0]       proc2Icache_addr,
    output logic [63:0]       Icache_data_out,
    output logic              Icache_valid_out,
    output logic [IDX_W-1:0]  cache_rd_idx,
    output logic [TAG_W-1:0]  cache_rd_tag,
    input  logic [63:0]       cache_rd_data,
    input  logic              cache_rd_valid,
    output logic              cache_wr_en,
    output logic [IDX_W-1:0]  cache_wr_idx,
    output logic [TAG_W-1:0]  cache_wr_tag,
    output logic [63:0]       cache_wr_data,
    output logic [1:0]        mem_command,
    output logic [31:0]       mem_addr,
    input  logic [MTAG_W-1:0] mem_response,
    input  logic [63:0]       mem_data,
    input  logic [MTAG_W-1:0] mem_tag,
    output logic [31:0]       miss_count
);

    ic_state_e         state_q, state_d;
    logic [MTAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [TAG_W-1:0]  pend_cache_tag_q, pend_cache_tag_d;
    logic [31:0]       miss_count_q, miss_count_d;
    bus_cmd_e          cmd;

    // Address split feeding the array lookup; the index sits above the block offset.
    assign cache_rd_idx = proc2Icache_addr[3 +: IDX_W];
    assign cache_rd_tag = proc2Icache_addr[3 + IDX_W +: TAG_W];

    // Hit path is purely combinational. A fill to the fetched line does not make
    // it a hit in the same cycle because the array write only lands at the edge.
    assign Icache_valid_out = proc2Icache_req & cache_rd_valid;
    assign Icache_data_out  = cache_rd_data;

    // The load address is always the aligned fetch address; it only matters while
    // mem_command is BUS_LOAD.
    assign mem_addr    = block_align(proc2Icache_addr);
    assign mem_command = cmd;
    assign miss_count  = miss_count_q;

    always_comb begin
        state_d          = state_q;
        pend_tag_d       = pend_tag_q;
        pend_idx_d       = pend_idx_q;
        pend_cache_tag_d = pend_cache_tag_q;
        miss_count_d     = miss_count_q;
        cmd              = BUS_NONE;
        cache_wr_en      = 1'b0;
        cache_wr_idx     = pend_idx_q;
        cache_wr_tag     = pend_cache_tag_q;
        cache_wr_data    = mem_data;

        case (state_q)
            ST_IDLE: begin
                // An unaccepted request leaves no state behind, so a new address
                // next cycle simply replaces it.
                if (proc2Icache_req && !cache_rd_valid) begin
                    cmd = BUS_LOAD;
                    if (mem_response != '0) begin
                        pend_tag_d       = mem_response;
                        pend_idx_d       = cache_rd_idx;
                        pend_cache_tag_d = cache_rd_tag;
                        miss_count_d     = miss_count_q + 32'd1;
                        state_d          = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Fill uses the latched line, independent of where fetch has moved.
                // A zero mem_tag is never a match, so a cleared pend_tag cannot fire.
                if ((mem_tag != '0) && (mem_tag == pend_tag_q)) begin
                    cache_wr_en = 1'b1;
                    pend_tag_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            pend_tag_q       <= '0;
            pend_idx_q       <= '0;
            pend_cache_tag_q <= '0;
            miss_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            pend_tag_q       <= pend_tag_d;
            pend_idx_q       <= pend_idx_d;
            pend_cache_tag_q <= pend_cache_tag_d;
            miss_count_q     <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl with a behavioural array and miss model
module tb_icache_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        proc2Icache_req;
    logic [31:0] proc2Icache_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [4:0]  cache_rd_idx;
    logic [7:0]  cache_rd_tag;
    logic [63:0] cache_rd_data;
    logic        cache_rd_valid;
    logic        cache_wr_en;
    logic [4:0]  cache_wr_idx;
    logic [7:0]  cache_wr_tag;
    logic [63:0] cache_wr_data;
    logic [1:0]  mem_command;
    logic [31:0] mem_addr;
    logic [3:0]  mem_response;
    logic [63:0] mem_data;
    logic [3:0]  mem_tag;
    logic [31:0] miss_count;

    icache_ctrl dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .proc2Icache_req  (proc2Icache_req),
        .proc2Icache_addr (proc2Icache_addr),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .cache_rd_idx     (cache_rd_idx),
        .cache_rd_tag     (cache_rd_tag),
        .cache_rd_data    (cache_rd_data),
        .cache_rd_valid   (cache_rd_valid),
        .cache_wr_en      (cache_wr_en),
        .cache_wr_idx     (cache_wr_idx),
        .cache_wr_tag     (cache_wr_tag),
        .cache_wr_data    (cache_wr_data),
        .mem_command      (mem_command),
        .mem_addr         (mem_addr),
        .mem_response     (mem_response),
        .mem_data         (mem_data),
        .mem_tag          (mem_tag),
        .miss_count       (miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic [1:0]  cmd;
        logic        wr;
        logic        vld;
        logic [4:0]  ridx;
        logic [7:0]  rtag;
    } st_t;
    typedef struct { int cyc; logic [31:0] addr; } ld_t;
    typedef struct { int cyc; logic [63:0] data; } hit_t;
    typedef struct { int cyc; logic [4:0] idx; logic [7:0] tag; logic [63:0] data; } wr_t;

    st_t  sq[$];
    ld_t  lq[$];
    hit_t hq[$];
    wr_t  wq[$];

    int n_vec = 0;
    int n_err = 0;
    int cur_cyc = 0;

    // Reference model: one pending miss plus the contents of the 32-line array.
    bit          m_pend;
    logic [3:0]  m_ptag;
    logic [4:0]  m_pidx;
    logic [7:0]  m_pctag;
    logic [31:0] m_cnt;
    bit          arr_v[32];
    logic [7:0]  arr_t[32];
    logic [63:0] arr_d[32];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cur_cyc, act, exp);
        end
    endfunction

    // One clock of stimulus: drive inputs, queue what the DUT must show this
    // cycle, then advance the model across the edge.
    task automatic cycle(input bit rst, input bit req, input logic [31:0] addr,
                         input logic [3:0] resp, input logic [3:0] mtag,
                         input logic [63:0] mdata);
        int         idx;
        logic [7:0] tg;
        bit         hit, load, acc, fill;
        st_t        s;
        idx = int'(addr / 8) % 32;
        tg  = 8'((addr / 256) % 256);
        cur_cyc++;
        reset_n          = !rst;
        proc2Icache_req  = req;
        proc2Icache_addr = addr;
        mem_response     = resp;
        mem_tag          = mtag;
        mem_data         = mdata;
        hit              = arr_v[idx] && (arr_t[idx] == tg);
        cache_rd_valid   = hit;
        cache_rd_data    = hit ? arr_d[idx] : {$urandom, $urandom};
        if (rst) begin
            m_pend = 0; m_ptag = 0; m_pidx = 0; m_pctag = 0; m_cnt = 0;
        end
        load = !m_pend && req && !hit;
        acc  = load && (resp != 0) && !rst;
        fill = m_pend && (mtag != 0) && (mtag == m_ptag);
        s.cyc = cur_cyc; s.cnt = m_cnt; s.cmd = load ? 2'd1 : 2'd0;
        s.wr = fill; s.vld = req && hit; s.ridx = 5'(idx); s.rtag = tg;
        sq.push_back(s);
        if (load)       lq.push_back('{cur_cyc, addr & ~32'h7});
        if (req && hit) hq.push_back('{cur_cyc, arr_d[idx]});
        if (fill)       wq.push_back('{cur_cyc, m_pidx, m_pctag, mdata});
        @(posedge clock);
        if (fill) begin
            arr_v[m_pidx] = 1; arr_t[m_pidx] = m_pctag; arr_d[m_pidx] = mdata;
            m_pend = 0; m_ptag = 0;
        end
        if (acc) begin
            m_pend = 1; m_ptag = resp; m_pidx = 5'(idx); m_pctag = tg;
            m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    // Monitor: compares the per-cycle status and pops event expectations
    // whenever the DUT presents a load, a hit or a fill.
    always @(negedge clock) begin
        if (sq.size() != 0) begin
            st_t s;
            s = sq.pop_front();
            chk("cyc_align", 64'(cur_cyc), 64'(s.cyc));
            chk("miss_count", 64'(miss_count), 64'(s.cnt));
            chk("mem_command", 64'(mem_command), 64'(s.cmd));
            chk("cache_wr_en", 64'(cache_wr_en), 64'(s.wr));
            chk("valid_out", 64'(Icache_valid_out), 64'(s.vld));
            chk("rd_idx", 64'(cache_rd_idx), 64'(s.ridx));
            chk("rd_tag", 64'(cache_rd_tag), 64'(s.rtag));
            if (mem_command == 2'd1) begin
                if (lq.size() == 0) chk("load_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    ld_t l;
                    l = lq.pop_front();
                    chk("load_cyc", 64'(cur_cyc), 64'(l.cyc));
                    chk("mem_addr", 64'(mem_addr), 64'(l.addr));
                end
            end
            if (Icache_valid_out) begin
                if (hq.size() == 0) chk("hit_unexpected", 64'(Icache_valid_out), 64'd0);
                else begin
                    hit_t h;
                    h = hq.pop_front();
                    chk("hit_cyc", 64'(cur_cyc), 64'(h.cyc));
                    chk("hit_data", Icache_data_out, h.data);
                end
            end
            if (cache_wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", 64'(cache_wr_en), 64'd0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_cyc", 64'(cur_cyc), 64'(w.cyc));
                    chk("wr_idx", 64'(cache_wr_idx), 64'(w.idx));
                    chk("wr_tag", 64'(cache_wr_tag), 64'(w.tag));
                    chk("wr_data", cache_wr_data, w.data);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cur_cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  r, t;
        int          sel;
        reset_n = 1'b0;
        proc2Icache_req = 1'b0; proc2Icache_addr = '0;
        mem_response = '0; mem_tag = '0; mem_data = '0;
        cache_rd_valid = 1'b0; cache_rd_data = '0;
        for (int i = 0; i < 32; i++) begin arr_v[i] = 0; arr_t[i] = 0; arr_d[i] = 0; end
        repeat (2) @(posedge clock);
        #1;
        // Reset with no request
        cycle(1, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 0, 0, 0);
        // Miss accepted with tag 3, fill on the fetched line, hit next cycle
        cycle(0, 1, 32'h0000_0108, 4'd3, 0, 0);
        cycle(0, 0, 32'h0, 0, 0, 0);
        cycle(0, 1, 32'h0000_0108, 0, 4'd3, 64'hDEAD_BEEF_0000_0001);
        cycle(0, 1, 32'h0000_0108, 0, 0, 0);
        // Unaccepted miss abandoned when the address moves
        cycle(0, 1, 32'h0000_0300, 0, 0, 0);
        cycle(0, 1, 32'h0000_0300, 0, 0, 0);
        cycle(0, 1, 32'h0000_0300, 0, 0, 0);
        cycle(0, 1, 32'h0000_0200, 4'd4, 0, 0);
        cycle(0, 0, 32'h0, 0, 4'd4, 64'h1111_2222_3333_4444);
        // WAIT with pend_tag 5: foreign tag ignored, hit served, redirect, then fill
        cycle(0, 1, 32'h0000_0400, 4'd5, 0, 0);
        cycle(0, 1, 32'h0000_0108, 0, 4'd2, 64'hBAD0_BAD0_BAD0_BAD0);
        cycle(0, 1, 32'h0000_0900, 4'd6, 0, 0);
        cycle(0, 1, 32'h0000_0900, 0, 4'd5, 64'h5555_AAAA_5555_AAAA);
        cycle(0, 1, 32'h0000_0900, 0, 0, 0);
        cycle(0, 1, 32'h0000_0400, 0, 0, 0);
        // Reset in WAIT discards transaction 7
        cycle(0, 1, 32'h0000_1238, 4'd7, 0, 0);
        cycle(1, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 0, 4'd7, 64'h7777_7777_7777_7777);
        cycle(0, 1, 32'h0000_1238, 0, 4'd7, 64'h7777_7777_7777_7777);
        // Randomized traffic over a small address pool so lines get reused
        for (int i = 0; i < 3000; i++) begin
            a = {16'($urandom), 8'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom)};
            r = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            sel = $urandom_range(0, 3);
            if (sel == 0)                t = 4'd0;
            else if (sel == 1 && m_pend) t = m_ptag;
            else                         t = 4'($urandom);
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, a, r, t,
                  {$urandom, $urandom});
        end
        cycle(0, 0, 32'h0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        chk("load_leftover", 64'(lq.size()), 64'd0);
        chk("hit_leftover", 64'(hq.size()), 64'd0);
        chk("wr_leftover", 64'(wq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
